outlier_window_detector: RTL

//  Parametrised outlier detector: captures a W-bit sample on each slow new_number strobe and compares it

---
 rtl/outlier_window_detector.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/outlier_window_detector.sv
// -----------------------------------------------------------------------------
// outlier_window_detector
//
// Purpose:
//   Captures a W-bit sample on each rising edge of the slow, asynchronous
//   new_number strobe and compares it against the truncated mean of the last
//   DEPTH = 2**LOG2_DEPTH accepted samples. The result flag is set when
//   |x - mean| > threshold, once the window has filled. Until then the flag
//   stays 0 while the window warms up.
//
// Build option:
//   OUTLIER_REJECT_EN - when defined, a sample that raised the flag is not
//                       written into the window. Warm-up samples are always
//                       accepted. When undefined, every sample is written.
//
// Ports:
//   clk           in   1              system clock, rising edge
//   reset         in   1              asynchronous, active-low reset
//   new_number    in   1              async level strobe, rising edge = sample
//   data_in       in   W              sample value, stable while strobe high
//   threshold     in   W              outlier threshold, sampled in CAPTURE
//   flag          out  1              result of the last comparison
//   done          out  1              one-cycle pulse when flag updates
//   busy          out  1              high whenever the FSM is not IDLE
//   window_full   out  1              high once DEPTH samples are accepted
//   sample_count  out  LOG2_DEPTH+1   accepted samples, saturates at DEPTH
// -----------------------------------------------------------------------------
module outlier_window_detector #(
  parameter int W           = 8,
  parameter int LOG2_DEPTH  = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  new_number,
  input  logic [W-1:0]          data_in,
  input  logic [W-1:0]          threshold,
  output logic                  flag,
  output logic                  done,
  output logic                  busy,
  output logic                  window_full,
  output logic [LOG2_DEPTH:0]   sample_count
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int SW    = W + LOG2_DEPTH;  // the sum of DEPTH W-bit samples fits exactly
  localparam logic [LOG2_DEPTH:0] DEPTH_CNT = (LOG2_DEPTH+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    COMPARE = 2'd2,
    UPDATE  = 2'd3
  } state_e;

  // ---------------------------------------------------------------------------
  // Strobe synchroniser and rising-edge detector
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_prev_q;
  logic                   strb_q;

  // NOTE: sequential state uses non-blocking (<=) assignments so that every
  // flop samples its input as it was before the clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q      <= '0;
      sync_prev_q <= 1'b0;
      strb_q      <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], new_number};
      sync_prev_q <= sync_q[SYNC_STAGES-1];
      strb_q      <= sync_q[SYNC_STAGES-1] & ~sync_prev_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath and control state
  // ---------------------------------------------------------------------------
  state_e                state_q, state_d;
  logic [W-1:0]          x_q, x_d;
  logic [W-1:0]          thr_q, thr_d;
  logic                  flag_q, flag_d;
  logic                  done_q, done_d;
  logic [SW-1:0]         sum_q, sum_d;
  logic [LOG2_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG2_DEPTH:0]   count_q, count_d;
  logic                  win_we;
  logic [W-1:0]          win_q [DEPTH];

  logic                  full;
  logic [W-1:0]          mean;
  logic [W:0]            diff;
  logic [W-1:0]          oldest;
  logic                  accept;

  assign full   = (count_q == DEPTH_CNT);
  assign mean   = sum_q[SW-1:LOG2_DEPTH];
  assign diff   = (x_q >= mean) ? {1'b0, x_q - mean} : {1'b0, mean - x_q};
  assign oldest = win_q[wr_ptr_q];

`ifdef OUTLIER_REJECT_EN
  // flag_q already holds this sample's result when UPDATE runs. It is
  // always 0 during warm-up, so warm-up samples are never rejected.
  assign accept = ~flag_q;
`else
  assign accept = 1'b1;
`endif

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    thr_d    = thr_q;
    flag_d   = flag_q;
    done_d   = 1'b0;
    sum_d    = sum_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    win_we   = 1'b0;

    case (state_q)
      IDLE: begin
        // A strobe seen in any other state is dropped, not queued.
        if (strb_q) state_d = CAPTURE;
      end
      CAPTURE: begin
        x_d     = data_in;
        thr_d   = threshold;
        state_d = COMPARE;
      end
      COMPARE: begin
        flag_d  = full && (diff > {1'b0, thr_q});
        done_d  = 1'b1;
        state_d = UPDATE;
      end
      UPDATE: begin
        if (accept) begin
          win_we   = 1'b1;
          // The evicted sample only counts once the window holds DEPTH samples.
          sum_d    = sum_q + SW'(x_q) - (full ? SW'(oldest) : SW'(0));
          wr_ptr_d = wr_ptr_q + LOG2_DEPTH'(1);
          if (!full) count_d = count_q + (LOG2_DEPTH+1)'(1);
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      x_q      <= '0;
      thr_q    <= '0;
      flag_q   <= 1'b0;
      done_q   <= 1'b0;
      sum_q    <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      thr_q    <= thr_d;
      flag_q   <= flag_d;
      done_q   <= done_d;
      sum_q    <= sum_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the sample window has no reset. An entry is only ever read after
  // it has been written, because sum and sample_count are reset and gate
  // every use of the window.
  always_ff @(posedge clk) begin
    if (win_we) win_q[wr_ptr_q] <= x_q;
  end

  assign flag         = flag_q;
  assign done         = done_q;
  assign busy         = (state_q != IDLE);
  assign window_full  = full;
  assign sample_count = count_q;

endmodule
